// File: rtl/riscv_register_file_sb_pkg.sv
// Shared types, derived-size helpers and flattened-bus slicing macro for the register file.
package riscv_register_file_sb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // RA: port address width; the extra MSB (when FPU=1) selects the FP bank
    function automatic int calc_ra(input int addr_width, input int fpu);
        return addr_width + fpu;
    endfunction

    function automatic int calc_num_tot(input int addr_width, input int fpu);
        return 1 << (addr_width + fpu);
    endfunction

endpackage

`ifndef RF_SLICE
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

// File: rtl/riscv_register_file_sb_if.sv
// Read/write/reserve/clear bus between the ID stage and the register file.
interface riscv_register_file_sb_if #(
    parameter int RA         = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2
);
    logic [NUM_RPORTS*RA-1:0]         raddr_i;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o;
    logic [NUM_RPORTS-1:0]            rbusy_o;
    logic [NUM_WPORTS*RA-1:0]         waddr_i;
    logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_WPORTS-1:0]            we_i;
    logic                             rsv_i;
    logic [RA-1:0]                    rsv_addr_i;
    logic                             clear_req_i;
    logic                             clear_busy_o;
    logic                             clear_done_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i, rsv_i, rsv_addr_i, clear_req_i,
        input  rdata_o, rbusy_o, clear_busy_o, clear_done_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i, rsv_i, rsv_addr_i, clear_req_i,
        output rdata_o, rbusy_o, clear_busy_o, clear_done_o
    );
endinterface

// File: rtl/riscv_register_file_sb_wr_arbiter.sv
// Per-register write-port priority resolution; also supplies the bypass hit/data for reads.
module riscv_rf_wr_arbiter #(
    parameter int RA         = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WPORTS = 2,
    parameter int BYPASS     = 1
) (
    input  logic                                   enable,
    input  logic [NUM_WPORTS*RA-1:0]               waddr,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0]       wdata,
    input  logic [NUM_WPORTS-1:0]                  we,
    output logic [(1<<RA)-1:0]                     wr_en,
    output logic [(1<<RA)-1:0][DATA_WIDTH-1:0]     wr_data,
    output logic [(1<<RA)-1:0]                     byp_hit
);
    localparam int NUM_TOT = 1 << RA;

    // Ascending port scan lets the highest-index port overwrite; index 0 (integer x0) is never written
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int i = 1; i < NUM_TOT; i++) begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (enable && we[p] && (`RF_SLICE(waddr, p, RA) == RA'(i))) begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = `RF_SLICE(wdata, p, DATA_WIDTH);
                end
            end
        end
    end

    assign byp_hit = (BYPASS != 0) ? wr_en : '0;

endmodule

// File: rtl/riscv_register_file_sb.sv
// Parametrised integer/FP register file with busy scoreboard and sequential bulk-clear engine.
module riscv_register_file_sb
    import riscv_register_file_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int BYPASS     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    riscv_register_file_sb_if.slave rf
);
    localparam int RA      = calc_ra(ADDR_WIDTH, FPU);
    localparam int NUM_TOT = calc_num_tot(ADDR_WIDTH, FPU);

    logic [DATA_WIDTH-1:0]                 regs [NUM_TOT];
    logic [NUM_TOT-1:0]                    busy;
    clr_state_t                            state;
    logic [RA-1:0]                         clr_cnt;
    logic                                  clear_busy;
    logic                                  clear_done;
    logic                                  idle;
    logic [NUM_TOT-1:0]                    wr_en;
    logic [NUM_TOT-1:0][DATA_WIDTH-1:0]    wr_data;
    logic [NUM_TOT-1:0]                    byp_hit;
    logic [NUM_TOT-1:0]                    rsv_hit;
    logic [NUM_RPORTS-1:0][RA-1:0]         raddr;
    logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata;
    logic [NUM_RPORTS-1:0]                 rbusy;

    assign idle  = (state == IDLE);
    assign raddr = rf.raddr_i;

    // Gating with idle drops writes and bypass while the clear engine owns the array
    riscv_rf_wr_arbiter #(
        .RA         (RA),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WPORTS (NUM_WPORTS),
        .BYPASS     (BYPASS)
    ) u_wr_arbiter (
        .enable  (idle),
        .waddr   (rf.waddr_i),
        .wdata   (rf.wdata_i),
        .we      (rf.we_i),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .byp_hit (byp_hit)
    );

    always_comb begin
        rsv_hit = '0;
        if (idle && rf.rsv_i && (rf.rsv_addr_i != '0))
            rsv_hit[rf.rsv_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TOT; i++)
                regs[i] <= '0;
            busy <= '0;
        end else if (state == CLEAR) begin
            regs[clr_cnt] <= '0;
            busy[clr_cnt] <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TOT; i++) begin
                if (wr_en[i])
                    regs[i] <= wr_data[i];
                // A same-cycle reserve marks a new producer, so it overrides the write's release
                if (rsv_hit[i])
                    busy[i] <= 1'b1;
                else if (wr_en[i])
                    busy[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clear_done <= 1'b0;
                    if (rf.clear_req_i) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == RA'(NUM_TOT - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NUM_RPORTS; k++) begin
            rdata[k] = regs[raddr[k]];
            rbusy[k] = busy[raddr[k]];
            if (byp_hit[raddr[k]]) begin
                rdata[k] = wr_data[raddr[k]];
                if (!rsv_hit[raddr[k]])
                    rbusy[k] = 1'b0;
            end
        end
    end

    assign rf.rdata_o      = rdata;
    assign rf.rbusy_o      = rbusy;
    assign rf.clear_busy_o = clear_busy;
    assign rf.clear_done_o = clear_done;

endmodule

// File: tb/tb_riscv_register_file_sb.sv
// Bench for riscv_register_file_sb: an integer-only bypassing instance and an FPU non-bypassing instance.
module tb_riscv_register_file_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus per instance d (0: FPU=0/BYPASS=1/2 wports, 1: FPU=1/BYPASS=0/3 wports)
    logic [5:0]  raddr [2][3];
    logic [5:0]  wa    [2][3];
    logic [31:0] wd    [2][3];
    logic        we    [2][3];
    logic        rsv   [2];
    logic [5:0]  rsv_a [2];
    logic        clr   [2];

    riscv_register_file_sb_if #(.RA(5), .DATA_WIDTH(32), .NUM_RPORTS(3), .NUM_WPORTS(2)) bus0 ();
    riscv_register_file_sb_if #(.RA(6), .DATA_WIDTH(32), .NUM_RPORTS(3), .NUM_WPORTS(3)) bus1 ();

    assign bus0.raddr_i     = {raddr[0][2][4:0], raddr[0][1][4:0], raddr[0][0][4:0]};
    assign bus0.waddr_i     = {wa[0][1][4:0], wa[0][0][4:0]};
    assign bus0.wdata_i     = {wd[0][1], wd[0][0]};
    assign bus0.we_i        = {we[0][1], we[0][0]};
    assign bus0.rsv_i       = rsv[0];
    assign bus0.rsv_addr_i  = rsv_a[0][4:0];
    assign bus0.clear_req_i = clr[0];

    assign bus1.raddr_i     = {raddr[1][2], raddr[1][1], raddr[1][0]};
    assign bus1.waddr_i     = {wa[1][2], wa[1][1], wa[1][0]};
    assign bus1.wdata_i     = {wd[1][2], wd[1][1], wd[1][0]};
    assign bus1.we_i        = {we[1][2], we[1][1], we[1][0]};
    assign bus1.rsv_i       = rsv[1];
    assign bus1.rsv_addr_i  = rsv_a[1];
    assign bus1.clear_req_i = clr[1];

    riscv_register_file_sb #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .FPU(0), .NUM_RPORTS(3), .NUM_WPORTS(2), .BYPASS(1)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus0.slave)
    );

    riscv_register_file_sb #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .FPU(1), .NUM_RPORTS(3), .NUM_WPORTS(3), .BYPASS(0)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus1.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: architectural register contents, busy bits and clear progress
    logic [31:0] m_mem      [2][64];
    logic        m_busy     [2][64];
    bit          m_clearing [2];
    int          m_ci       [2];
    bit          m_done     [2];

    function automatic int nt(input int d);
        return (d == 0) ? 32 : 64;
    endfunction

    function automatic int nw(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit byp(input int d);
        return (d == 0);
    endfunction

    function automatic logic [31:0] obs_rdata(input int d, input int k);
        return (d == 0) ? bus0.rdata_o[k*32 +: 32] : bus1.rdata_o[k*32 +: 32];
    endfunction

    function automatic logic obs_rbusy(input int d, input int k);
        return (d == 0) ? bus0.rbusy_o[k] : bus1.rbusy_o[k];
    endfunction

    function automatic logic obs_cbusy(input int d);
        return (d == 0) ? bus0.clear_busy_o : bus1.clear_busy_o;
    endfunction

    function automatic logic obs_cdone(input int d);
        return (d == 0) ? bus0.clear_done_o : bus1.clear_done_o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 64; a++) begin
                m_mem[d][a]  = '0;
                m_busy[d][a] = 1'b0;
            end
            m_clearing[d] = 1'b0;
            m_ci[d]       = 0;
            m_done[d]     = 1'b0;
        end
    endtask

    task automatic model_step();
        int a;
        for (int d = 0; d < 2; d++) begin
            if (m_clearing[d]) begin
                m_mem[d][m_ci[d]]  = '0;
                m_busy[d][m_ci[d]] = 1'b0;
                m_done[d]          = (m_ci[d] == nt(d) - 1);
                if (m_done[d])
                    m_clearing[d] = 1'b0;
                m_ci[d]++;
            end else begin
                m_done[d] = 1'b0;
                for (int p = 0; p < nw(d); p++) begin
                    a = int'(wa[d][p]);
                    if (we[d][p] && a != 0) begin
                        m_mem[d][a]  = wd[d][p];
                        m_busy[d][a] = 1'b0;
                    end
                end
                if (rsv[d] && rsv_a[d] != 6'd0)
                    m_busy[d][int'(rsv_a[d])] = 1'b1;
                if (clr[d]) begin
                    m_clearing[d] = 1'b1;
                    m_ci[d]       = 0;
                end
            end
        end
    endtask

    task automatic exp_read(input int d, input int k, output logic [31:0] data, output logic b);
        int   a;
        bit   hit;
        bit   rhit;
        logic [31:0] val;
        a    = int'(raddr[d][k]);
        data = m_mem[d][a];
        b    = m_busy[d][a];
        hit  = 1'b0;
        val  = '0;
        if (byp(d) && !m_clearing[d] && a != 0) begin
            for (int p = 0; p < nw(d); p++) begin
                if (we[d][p] && int'(wa[d][p]) == a) begin
                    hit = 1'b1;
                    val = wd[d][p];
                end
            end
            rhit = rsv[d] && (int'(rsv_a[d]) == a);
            if (hit) begin
                data = val;
                if (!rhit)
                    b = 1'b0;
            end
        end
    endtask

    // Compare every output against the model at the falling edge, then advance one clock
    task automatic cycle();
        logic [31:0] ed;
        logic        eb;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                exp_read(d, k, ed, eb);
                chk($sformatf("d%0d_rdata%0d", d, k), obs_rdata(d, k), ed);
                chk($sformatf("d%0d_rbusy%0d", d, k), {31'd0, obs_rbusy(d, k)}, {31'd0, eb});
            end
            chk($sformatf("d%0d_clear_busy", d), {31'd0, obs_cbusy(d)}, {31'd0, m_clearing[d]});
            chk($sformatf("d%0d_clear_done", d), {31'd0, obs_cdone(d)}, {31'd0, m_done[d]});
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 3; p++) begin
                raddr[d][p] = '0;
                wa[d][p]    = '0;
                wd[d][p]    = '0;
                we[d][p]    = 1'b0;
            end
            rsv[d]   = 1'b0;
            rsv_a[d] = '0;
            clr[d]   = 1'b0;
        end
    endtask

    task automatic set_wr(input int d, input int p, input logic [5:0] a, input logic [31:0] v);
        we[d][p] = 1'b1;
        wa[d][p] = a;
        wd[d][p] = v;
    endtask

    function automatic logic [5:0] gen_addr(input int d);
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 6'd0;
        if (r == 1) return 6'($urandom_range(1, 4));
        return 6'($urandom_range(0, nt(d) - 1));
    endfunction

    task automatic randomize_inputs(input bit allow_clr);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 3; p++) begin
                we[d][p] = (p < nw(d)) ? 1'($urandom_range(0, 1)) : 1'b0;
                wa[d][p] = gen_addr(d);
                wd[d][p] = $urandom;
            end
            for (int k = 0; k < 3; k++)
                raddr[d][k] = ($urandom_range(0, 1) == 1) ? wa[d][$urandom_range(0, nw(d) - 1)] : gen_addr(d);
            rsv[d]   = ($urandom_range(0, 3) == 0);
            rsv_a[d] = ($urandom_range(0, 1) == 1) ? wa[d][0] : gen_addr(d);
            clr[d]   = allow_clr && ($urandom_range(0, 99) == 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset state across every integer address
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 3; k++) begin
                raddr[0][k] = 6'(a);
                raddr[1][k] = 6'(a);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                chk("rst_rdata", obs_rdata(0, k), 32'h0);
                chk("rst_rbusy", {31'd0, obs_rbusy(0, k)}, 32'h0);
            end
            chk("rst_clear_busy", {31'd0, obs_cbusy(0)}, 32'h0);
            cycle();
        end

        // Write priority and bypass on the bypassing instance
        idle_inputs();
        set_wr(0, 0, 6'd5, 32'hDEADBEEF);
        set_wr(0, 1, 6'd5, 32'h12345678);
        raddr[0][0] = 6'd5;
        #1 chk("byp_prio", obs_rdata(0, 0), 32'h12345678);
        cycle();
        idle_inputs();
        raddr[0][0] = 6'd5;
        #1 chk("prio_commit", obs_rdata(0, 0), 32'h12345678);
        cycle();
        set_wr(0, 0, 6'd0, 32'hFFFFFFFF);
        raddr[0][0] = 6'd0;
        #1 chk("x0_byp", obs_rdata(0, 0), 32'h0);
        cycle();
        idle_inputs();
        #1 chk("x0_after", obs_rdata(0, 0), 32'h0);
        cycle();

        // No bypass on the FPU instance
        set_wr(1, 0, 6'd7, 32'hA5A5A5A5);
        raddr[1][0] = 6'd7;
        #1 chk("nobyp_old", obs_rdata(1, 0), 32'h0);
        cycle();
        idle_inputs();
        raddr[1][0] = 6'd7;
        #1 chk("nobyp_new", obs_rdata(1, 0), 32'hA5A5A5A5);
        cycle();

        // Scoreboard
        idle_inputs();
        rsv[0] = 1'b1; rsv_a[0] = 6'd9; raddr[0][1] = 6'd9;
        #1 chk("rsv_same_cycle", {31'd0, obs_rbusy(0, 1)}, 32'h0);
        cycle();
        idle_inputs();
        raddr[0][1] = 6'd9;
        #1 chk("rsv_busy", {31'd0, obs_rbusy(0, 1)}, 32'h1);
        set_wr(0, 0, 6'd9, 32'h00000099);
        #1 chk("wr_byp_busy", {31'd0, obs_rbusy(0, 1)}, 32'h0);
        chk("wr_byp_data", obs_rdata(0, 1), 32'h00000099);
        cycle();
        idle_inputs();
        raddr[0][1] = 6'd9;
        #1 chk("wr_clr_busy", {31'd0, obs_rbusy(0, 1)}, 32'h0);
        rsv[0] = 1'b1; rsv_a[0] = 6'd9;
        set_wr(0, 1, 6'd9, 32'h00000077);
        cycle();
        idle_inputs();
        raddr[0][1] = 6'd9;
        rsv[0] = 1'b1; rsv_a[0] = 6'd0;
        #1 chk("rsv_wr_busy", {31'd0, obs_rbusy(0, 1)}, 32'h1);
        chk("rsv_wr_data", obs_rdata(0, 1), 32'h00000077);
        cycle();
        idle_inputs();
        #1 chk("x0_rsv_dropped", {31'd0, obs_rbusy(0, 0)}, 32'h0);
        cycle();

        // FP bank separation and three-port priority
        set_wr(1, 0, 6'd3, 32'h00000033);
        cycle();
        idle_inputs();
        set_wr(1, 0, 6'h23, 32'h3F800000);
        cycle();
        idle_inputs();
        set_wr(1, 0, 6'h20, 32'h00000001);
        set_wr(1, 0, 6'd10, 32'h0000AAAA);
        set_wr(1, 1, 6'd10, 32'h0000BBBB);
        set_wr(1, 2, 6'd10, 32'h0000CCCC);
        cycle();
        idle_inputs();
        set_wr(1, 0, 6'h20, 32'h00000001);
        cycle();
        idle_inputs();
        raddr[1][0] = 6'd3; raddr[1][1] = 6'h23; raddr[1][2] = 6'h20;
        #1 chk("int3_unchanged", obs_rdata(1, 0), 32'h00000033);
        chk("fp3_written", obs_rdata(1, 1), 32'h3F800000);
        chk("fp0_written", obs_rdata(1, 2), 32'h00000001);
        raddr[1][0] = 6'd10;
        #1 chk("wport_prio3", obs_rdata(1, 0), 32'h0000CCCC);
        cycle();

        // Randomised traffic including occasional clears
        for (int i = 0; i < 400; i++) begin
            randomize_inputs(1'b1);
            cycle();
        end
        idle_inputs();
        while (m_clearing[0] || m_clearing[1] || m_done[0] || m_done[1]) cycle();

        // Bulk clear with writes/reserves issued during it
        for (int a = 1; a < 32; a++) begin
            idle_inputs();
            set_wr(0, 0, 6'(a), {8'(a), 24'hA5C3E1});
            rsv[0] = (a % 3 == 0); rsv_a[0] = 6'(a);
            cycle();
        end
        idle_inputs();
        clr[0] = 1'b1;
        cycle();
        for (int i = 0; i < 32; i++) begin
            idle_inputs();
            set_wr(0, 0, 6'($urandom_range(1, 31)), $urandom | 32'h1);
            set_wr(0, 1, 6'($urandom_range(1, 31)), $urandom | 32'h1);
            rsv[0] = 1'b1; rsv_a[0] = 6'($urandom_range(1, 31));
            clr[0] = 1'b1;
            for (int k = 0; k < 3; k++) raddr[0][k] = 6'($urandom_range(0, 31));
            #1 chk("clr_busy_high", {31'd0, obs_cbusy(0)}, 32'h1);
            chk("clr_no_done", {31'd0, obs_cdone(0)}, 32'h0);
            cycle();
        end
        idle_inputs();
        #1 chk("clr_busy_low", {31'd0, obs_cbusy(0)}, 32'h0);
        chk("clr_done_pulse", {31'd0, obs_cdone(0)}, 32'h1);
        cycle();
        #1 chk("clr_done_once", {31'd0, obs_cdone(0)}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 3; k++) raddr[0][k] = 6'(a);
            #1 chk("post_clr_rdata", obs_rdata(0, 0), 32'h0);
            chk("post_clr_rbusy", {31'd0, obs_rbusy(0, 0)}, 32'h0);
            cycle();
        end

        // Reset asserted during a clear on both instances
        for (int i = 0; i < 20; i++) begin
            randomize_inputs(1'b0);
            cycle();
        end
        idle_inputs();
        clr[0] = 1'b1; clr[1] = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 10; i++) cycle();
        rst_n = 1'b0;
        model_reset();
        #1 chk("midclr_rst_busy0", {31'd0, obs_cbusy(0)}, 32'h0);
        chk("midclr_rst_busy1", {31'd0, obs_cbusy(1)}, 32'h0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            for (int k = 0; k < 3; k++) begin
                raddr[0][k] = 6'(i % 32);
                raddr[1][k] = 6'(i % 64);
            end
            #1 chk("midclr_no_done", {31'd0, obs_cdone(0) | obs_cdone(1)}, 32'h0);
            chk("midclr_rdata1", obs_rdata(1, 0), 32'h0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_register_file_sb.md
Name: riscv_register_file_sb

Overview:
- Parametrised successor to the core's integer/FP register file.
- Configurable numbers of read and write ports.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for long-latency producers (LSU, mult/div, FPU).
- Sequential bulk-clear engine, used on debug reset / context flush.
- Sits in the ID stage: read ports feed the operand muxes, write ports come from EX/WB.

Parameters:
ADDR_WIDTH, 5, index width within one bank (2**ADDR_WIDTH registers per bank)
DATA_WIDTH, 32, register width
FPU, 0, 1 adds an FP bank; port address width becomes RA = ADDR_WIDTH+FPU, MSB selects the FP bank
NUM_RPORTS, 3, number of read ports (1..4)
NUM_WPORTS, 2, number of write ports (1..3); higher index = higher priority
BYPASS, 1, 1 forwards same-cycle write data to reads

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
raddr_i  in  NUM_RPORTS*RA  read addresses, port k at [k*RA +: RA]
rdata_o  out  NUM_RPORTS*DATA_WIDTH  read data, combinational
rbusy_o  out  NUM_RPORTS  scoreboard busy for each read address
waddr_i  in  NUM_WPORTS*RA  write addresses
wdata_i  in  NUM_WPORTS*DATA_WIDTH  write data
we_i  in  NUM_WPORTS  write enables
rsv_i  in  1  reserve request: mark rsv_addr_i busy
rsv_addr_i  in  RA  register to reserve
clear_req_i  in  1  start bulk clear (pulse)
clear_busy_o  out  1  clear engine active
clear_done_o  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (asynchronous, active-low):
  - All registers in both banks = 0; all busy bits = 0.
  - FSM = IDLE; clear_busy_o = 0; clear_done_o = 0.
- Integer register 0:
  - Always reads 0, never busy; writes and reserves to it are dropped.
  - FP register 0 is an ordinary register.
- Write:
  - Takes effect at posedge when we_i[p] = 1.
  - Several ports hitting the same address in one cycle: the highest-index port wins.
  - Ports hitting different addresses all commit.
- Read:
  - Combinational from the array.
  - BYPASS=1: if any enabled write this cycle targets raddr (and raddr is not integer register 0), rdata returns the winning port's wdata. BYPASS=0: rdata returns the old value; the new value is visible the next cycle.
- Scoreboard, one busy bit per register:
  - rsv_i sets busy[rsv_addr_i] at posedge.
  - Any enabled write to an address clears its busy bit at posedge.
  - Reserve and write to the same address in the same cycle: busy ends set (the new producer wins); the data is still written.
  - rbusy_o[k] = busy[raddr_k], except with BYPASS=1 it is 0 when a same-cycle write hits that address and no same-cycle reserve targets it.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req_i; the counter loads 0.
  - In CLEAR: each cycle, register[counter] <= 0 and busy[counter] <= 0; counter increments across both banks (NUM_TOT = 2**RA entries, integer register 0 included harmlessly).
  - CLEAR -> IDLE after the cycle that clears index NUM_TOT-1; clear_done_o = 1 for exactly the next cycle.
  - Total duration = NUM_TOT cycles; clear_busy_o = 1 throughout CLEAR.
  - During CLEAR, we_i and rsv_i are ignored and clear_req_i is ignored.
  - Reads stay live: they see already-cleared entries as 0; bypass is disabled.
- Reset asserted mid-clear: immediate return to IDLE, everything zero, no clear_done_o.
- No internal write-conflict error; the priority rule is the contract.

Decomposition:
- Shared package / header holds:
  - Derived constants RA and NUM_TOT.
  - FSM state encodings (IDLE = 1'b0, CLEAR = 1'b1).
  - Port-slicing macros for the flattened buses.
- One sub-module, riscv_rf_wr_arbiter. Per register index it produces:
  - the merged write-enable (priority-resolved across write ports);
  - the selected write data;
  - the bypass hit/data used by the read muxes.
- Array, scoreboard, clear FSM and read muxes stay in the top module.

Test Plan:
- Reset, then read all ports at addresses 0..31 -> all rdata = 0, rbusy = 0, clear_busy_o = 0.
- Write 0xDEADBEEF to integer register 5 via port 0 and 0x12345678 via port 1 in the same cycle; read 5 in that cycle with BYPASS=1 -> 0x12345678. Next cycle -> 0x12345678. Write 0xFFFFFFFF to integer register 0 -> reads 0.
- BYPASS=0: write 0xA5A5A5A5 to register 7 and read 7 in the same cycle -> old value 0. Next cycle -> 0xA5A5A5A5.
- Scoreboard:
  - rsv_i on register 9 -> rbusy = 1 from the next cycle.
  - Write register 9 -> busy cleared after the edge; same-cycle bypass view = 0.
  - Reserve and write register 9 together -> busy stays 1 and the data is updated.
- FPU=1: write 0x3F800000 to address 6'b100011 (FP register 3) -> integer register 3 unchanged. FP register 0 holds 0x1 after a write.
- Fill registers 1..31 with non-zero values, pulse clear_req_i:
  - clear_busy_o high for 32 cycles; writes issued during the clear are lost.
  - clear_done_o pulses once; all reads = 0 afterwards.
  - Repeat with rst_n asserted at cycle 10 of the clear -> IDLE, all zero, no done pulse.
